ula_display: RTL and testbench

Downstream display stage for the `ula` block. It samples the 8-bit `saida` result and the `switchs` operation code, and converts the value to three BCD digits plus a sign with a sequential double-dabble engine. It then drives a multiplexed 4-digit common-anode 7-segment display. It sits between the combinational ALU and the board's display pins.

---
 rtl/ula_display.sv | 153 +++++++++++++++
 tb/tb_ula_display.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ula_display.sv
// ula_display: samples the ALU result, converts it to sign + 3 BCD digits with a serial double-dabble,
// and scans a 4-digit common-anode 7-segment display. Option macro: ULA_DISPLAY_ZERO_BLANK_EN.
//   state    | meaning
//   OCIOSO   | idle, watching {modo, saida} for a change
//   CONVERTE | one double-dabble iteration per clock, 8 in total
//   ATUALIZA | copy the finished conversion into the display digits
module ula_display #(
    parameter int DIV_REFRESH = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] saida,
    input  logic [3:0] switchs,
    output logic [3:0] anodos,
    output logic [6:0] segmentos,
    output logic       ocupado
);
    localparam int PW = (DIV_REFRESH > 1) ? $clog2(DIV_REFRESH) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV_REFRESH - 1);

    typedef enum logic [1:0] {OCIOSO, CONVERTE, ATUALIZA} state_t;

    state_t        state, state_next;
    logic          modo;
    logic [8:0]    atual;
    logic [8:0]    ultimo;
    logic          captura;
    logic [2:0]    iter;
    logic [7:0]    mag;
    logic [11:0]   bcd;
    logic [11:0]   bcd_aj;
    logic          sinal_conv;
    logic [3:0]    dig_u, dig_t, dig_h;
    logic          sinal;
    logic [PW-1:0] pres;
    logic [1:0]    idx;
    logic [6:0]    seg_atual;
    logic          blank_h, blank_t;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 7'b1000000;
            4'd1: seg7 = 7'b1111001;
            4'd2: seg7 = 7'b0100100;
            4'd3: seg7 = 7'b0110000;
            4'd4: seg7 = 7'b0011001;
            4'd5: seg7 = 7'b0010010;
            4'd6: seg7 = 7'b0000010;
            4'd7: seg7 = 7'b1111000;
            4'd8: seg7 = 7'b0000000;
            4'd9: seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    function automatic logic [3:0] add3(input logic [3:0] n);
        add3 = (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    assign modo    = (switchs == 4'b0001);
    assign atual   = {modo, saida};
    assign captura = (state == OCIOSO) && (atual != ultimo);
    assign bcd_aj  = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
    assign ocupado = (state != OCIOSO);

    always_ff @(posedge clk) begin
        if (reset) state <= OCIOSO;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            OCIOSO:   if (captura) state_next = CONVERTE;
            CONVERTE: if (iter == 3'd0) state_next = ATUALIZA;
            ATUALIZA: state_next = OCIOSO;
            default:  state_next = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ultimo     <= '0;
            iter       <= '0;
            mag        <= '0;
            bcd        <= '0;
            sinal_conv <= 1'b0;
            dig_u      <= '0;
            dig_t      <= '0;
            dig_h      <= '0;
            sinal      <= 1'b0;
        end else begin
            case (state)
                OCIOSO: if (captura) begin
                    ultimo     <= atual;
                    mag        <= (modo && saida[7]) ? (~saida + 8'd1) : saida;
                    sinal_conv <= modo && saida[7];
                    bcd        <= '0;
                    iter       <= 3'd7;
                end
                CONVERTE: begin
                    {bcd, mag} <= {bcd_aj, mag} << 1;
                    iter       <= iter - 3'd1;
                end
                ATUALIZA: begin
                    dig_h <= bcd[11:8];
                    dig_t <= bcd[7:4];
                    dig_u <= bcd[3:0];
                    sinal <= sinal_conv;
                end
                default: ;
            endcase
        end
    end

`ifdef ULA_DISPLAY_ZERO_BLANK_EN
    assign blank_h = (dig_h == 4'd0);
    assign blank_t = blank_h && (dig_t == 4'd0);
`else
    assign blank_h = 1'b0;
    assign blank_t = 1'b0;
`endif

    always_comb begin
        seg_atual = 7'b1111111;
        case (idx)
            2'd0: seg_atual = seg7(dig_u);
            2'd1: seg_atual = blank_t ? 7'b1111111 : seg7(dig_t);
            2'd2: seg_atual = blank_h ? 7'b1111111 : seg7(dig_h);
            2'd3: seg_atual = sinal ? 7'b0111111 : 7'b1111111;
            default: seg_atual = 7'b1111111;
        endcase
    end

    // Outputs follow the index held before the edge, so each digit dwells exactly DIV_REFRESH cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            pres      <= '0;
            idx       <= '0;
            anodos    <= 4'b1111;
            segmentos <= 7'b1111111;
        end else begin
            if (pres == PRE_MAX) begin
                pres <= '0;
                idx  <= idx + 2'd1;
            end else begin
                pres <= pres + 1'b1;
            end
            anodos    <= ~(4'b0001 << idx);
            segmentos <= seg_atual;
        end
    end
endmodule

// File: tb/tb_ula_display.sv
// Bench for ula_display: an arithmetic model of value, latency and scan position checked every cycle,
// plus directed scenarios with literal segment expectations.
module tb_ula_display;
    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] saida;
    logic [3:0] switchs;
    logic [3:0] anodos;
    logic [6:0] segmentos;
    logic       ocupado;

    int total = 0;
    int bad   = 0;

    ula_display #(.DIV_REFRESH(DIV)) dut (
        .clk(clk), .reset(reset), .saida(saida), .switchs(switchs),
        .anodos(anodos), .segmentos(segmentos), .ocupado(ocupado)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // ---------------- model ----------------
    logic [6:0] code [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    bit         model_ok = 0;
    int         k, m_busy, mi, mg;
    logic [8:0] m_last;
    int         m_h, m_t, m_u, p_h, p_t, p_u;
    bit         m_s, p_s, cur_modo;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_busy;

    function automatic logic [6:0] shown(input int i);
        bit bh, bt;
        bh = 0; bt = 0;
`ifdef ULA_DISPLAY_ZERO_BLANK_EN
        bh = (m_h == 0);
        bt = bh && (m_t == 0);
`endif
        case (i)
            0: shown = code[m_u];
            1: shown = bt ? 7'h7F : code[m_t];
            2: shown = bh ? 7'h7F : code[m_h];
            default: shown = m_s ? 7'h3F : 7'h7F;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            model_ok = 1;
            k = 0; m_busy = 0; m_last = '0;
            m_h = 0; m_t = 0; m_u = 0; m_s = 0;
            e_an = 4'hF; e_seg = 7'h7F; e_busy = 0;
        end else if (model_ok) begin
            k++;
            mi = ((k - 1) / DIV) % 4;
            e_an = 4'hF & ~(4'b0001 << mi);
            e_seg = shown(mi);
            cur_modo = (switchs == 4'b0001);
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_h = p_h; m_t = p_t; m_u = p_u; m_s = p_s;
                end
            end else if ({cur_modo, saida} != m_last) begin
                m_last = {cur_modo, saida};
                p_s = cur_modo && saida[7];
                mg  = p_s ? 256 - int'(saida) : int'(saida);
                p_h = mg / 100; p_t = (mg / 10) % 10; p_u = mg % 10;
                m_busy = 9;
            end
            e_busy = (m_busy > 0);
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("model.anodos", anodos, e_an);
            chk("model.segmentos", segmentos, e_seg);
            chk("model.ocupado", ocupado, e_busy);
        end
    end

    // ---------------- directed ----------------
    task automatic wait_busy(input logic lvl, input int maxc, input string nm);
        int n = 0;
        while (ocupado !== lvl && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk(nm, ocupado, lvl);
    endtask

    task automatic scan_check(input string nm, input logic [6:0] s, input logic [6:0] h,
                              input logic [6:0] t, input logic [6:0] u);
        logic [6:0] got [4];
        for (int i = 0; i < 4; i++) got[i] = 'x;
        repeat (4 * DIV + 1) begin
            @(negedge clk);
            case (anodos)
                4'b1110: got[0] = segmentos;
                4'b1101: got[1] = segmentos;
                4'b1011: got[2] = segmentos;
                4'b0111: got[3] = segmentos;
                default: ;
            endcase
        end
        chk({nm, ".units"}, got[0], u);
        chk({nm, ".tens"}, got[1], t);
        chk({nm, ".hundreds"}, got[2], h);
        chk({nm, ".sign"}, got[3], s);
    endtask

    task automatic convert(input logic [3:0] sw, input logic [7:0] v);
        switchs = sw;
        saida   = v;
        wait_busy(1'b1, 3, "start");
        wait_busy(1'b0, 12, "done");
    endtask

    initial begin
        int n;
        reset = 1'b1; saida = 8'd0; switchs = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst.anodos", anodos, 4'hF);
        chk("rst.segmentos", segmentos, 7'h7F);
        chk("rst.ocupado", ocupado, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk("rel.anodos", anodos, 4'b1110);
        chk("rel.segmentos", segmentos, 7'h40);

        // unsigned 30, busy length
        saida = 8'd30;
        n = 0;
        @(negedge clk);
        while (ocupado === 1'b1 && n < 30) begin
            n++;
            @(negedge clk);
        end
        chk("busy_len", n, 9);
        scan_check("add30", 7'h7F, 7'h40, 7'h30, 7'h40);

        // signed -3
        convert(4'b0001, 8'hFD);
`ifdef ULA_DISPLAY_ZERO_BLANK_EN
        scan_check("sub_m3", 7'h3F, 7'h7F, 7'h7F, 7'h30);
`else
        scan_check("sub_m3", 7'h3F, 7'h40, 7'h40, 7'h30);
`endif

        // unsigned high bit, then 255
        convert(4'b0010, 8'hE1);
        scan_check("u225", 7'h7F, 7'h24, 7'h24, 7'h12);
        convert(4'b0000, 8'hFF);
        scan_check("u255", 7'h7F, 7'h24, 7'h12, 7'h12);

        // same reference value: other unsigned op code, same saida
        switchs = 4'b0011;
        repeat (5) begin
            @(negedge clk);
            chk("same_idle", ocupado, 1'b0);
        end

        // signed -128
        convert(4'b0001, 8'h80);
        scan_check("s_m128", 7'h3F, 7'h79, 7'h24, 7'h00);

        // change mid-conversion
        switchs = 4'b0000; saida = 8'd30;
        repeat (4) @(negedge clk);
        saida = 8'd225;
        wait_busy(1'b0, 20, "mid.first_done");
        @(negedge clk);
        chk("mid.recapture", ocupado, 1'b1);
        wait_busy(1'b0, 20, "mid.second_done");
        scan_check("mid225", 7'h7F, 7'h24, 7'h24, 7'h12);

        // reset mid-conversion
        saida = 8'd100;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rmid.ocupado", ocupado, 1'b0);
        chk("rmid.anodos", anodos, 4'hF);
        chk("rmid.segmentos", segmentos, 7'h7F);
        reset = 1'b0;
        @(negedge clk);
        chk("rmid.zero_units", segmentos, 7'h40);
        wait_busy(1'b1, 10, "rmid.restart");
        wait_busy(1'b0, 12, "rmid.done");
        scan_check("r100", 7'h7F, 7'h79, 7'h40, 7'h40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
